// File: rtl/iq_frame_feeder.sv
// Packs 16-bit I/Q samples in pairs into 32-bit layer-1 beats, forces a fixed frame length and appends zero pad beats.
// One cycle from the completing handshake to vld_out; s_ready drops only while zero-fill or pad beats are emitted.
module iq_frame_feeder #(
    parameter int FRAME_LEN = 1024,
    parameter int PAD_BEATS = 2,
    parameter int CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    input  logic        s_last,
    output logic        vld_out,
    output logic [31:0] data_out,
    output logic        sof_out,
    output logic        eof_out,
    output logic        frame_err,
    output logic [15:0] frames_cnt
);
    localparam int HALF  = FRAME_LEN / 2;
    localparam int PAD_W = (PAD_BEATS > 1) ? $clog2(PAD_BEATS) : 1;
    localparam int BCW   = (CNT_W > PAD_W) ? CNT_W : PAD_W;

    typedef enum logic [1:0] {ACCEPT, ZFILL, DROP, PAD} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] idx, idx_nxt;
    logic [15:0]      hold, hold_nxt;
    logic [BCW-1:0]   cnt, cnt_nxt;
    logic [BCW-1:0]   beat;
    logic             vld_nxt, sof_nxt, eof_nxt, err_nxt;
    logic [31:0]      dat_nxt;
    logic [15:0]      frames_nxt;
    logic             xfer, last_idx;

    assign s_ready  = ~rst & ((state == ACCEPT) || (state == DROP));
    assign xfer     = s_valid & s_ready;
    assign last_idx = (idx == CNT_W'(FRAME_LEN - 1));
    assign beat     = BCW'(idx >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACCEPT;
            idx        <= '0;
            hold       <= '0;
            cnt        <= '0;
            vld_out    <= 1'b0;
            data_out   <= '0;
            sof_out    <= 1'b0;
            eof_out    <= 1'b0;
            frame_err  <= 1'b0;
            frames_cnt <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            hold       <= hold_nxt;
            cnt        <= cnt_nxt;
            vld_out    <= vld_nxt;
            data_out   <= dat_nxt;
            sof_out    <= sof_nxt;
            eof_out    <= eof_nxt;
            frame_err  <= err_nxt;
            frames_cnt <= frames_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        hold_nxt   = hold;
        cnt_nxt    = cnt;
        vld_nxt    = 1'b0;
        dat_nxt    = '0;
        sof_nxt    = 1'b0;
        eof_nxt    = 1'b0;
        err_nxt    = 1'b0;
        frames_nxt = frames_cnt;

        case (state)
            ACCEPT: begin
                if (xfer) begin
                    if (!idx[0]) begin
                        hold_nxt = s_data;
                    end else begin
                        vld_nxt = 1'b1;
                        dat_nxt = {hold, s_data};
                        sof_nxt = (beat == '0);
                        eof_nxt = last_idx;
                    end

                    if (last_idx) begin
                        idx_nxt = '0;
                        cnt_nxt = '0;
                        if (s_last) begin
                            state_nxt = PAD;
                        end else begin
                            state_nxt = DROP;
                            err_nxt   = 1'b1;
                        end
                    end else if (s_last) begin
                        // Early end: flush a half-filled pair now, zero-fill the remaining beats.
                        idx_nxt = '0;
                        err_nxt = 1'b1;
                        if (!idx[0]) begin
                            vld_nxt = 1'b1;
                            dat_nxt = {s_data, 16'h0000};
                            sof_nxt = (beat == '0);
                            eof_nxt = (beat == BCW'(HALF - 1));
                        end
                        if (beat == BCW'(HALF - 1)) begin
                            state_nxt = PAD;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = ZFILL;
                            cnt_nxt   = beat + 1'b1;
                        end
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end

            ZFILL: begin
                vld_nxt = 1'b1;
                if (cnt == BCW'(HALF - 1)) begin
                    eof_nxt   = 1'b1;
                    state_nxt = PAD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            DROP: begin
                if (xfer && s_last) begin
                    state_nxt = PAD;
                    cnt_nxt   = '0;
                end
            end

            PAD: begin
                vld_nxt = 1'b1;
                if (cnt == BCW'(PAD_BEATS - 1)) begin
                    frames_nxt = frames_cnt + 1'b1;
                    state_nxt  = ACCEPT;
                    cnt_nxt    = '0;
                    idx_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            default: state_nxt = ACCEPT;
        endcase
    end
endmodule

// File: tb/tb_iq_frame_feeder.sv
// Randomized bench for iq_frame_feeder: per-frame reference model predicts every beat and its cycle.
module tb_iq_frame_feeder;
    localparam int FL   = 8;
    localparam int PAD  = 2;
    localparam int HALF = FL / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;
    logic        vld_out;
    logic [31:0] data_out;
    logic        sof_out;
    logic        eof_out;
    logic        frame_err;
    logic [15:0] frames_cnt;

    iq_frame_feeder #(.FRAME_LEN(FL), .PAD_BEATS(PAD)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .vld_out    (vld_out),
        .data_out   (data_out),
        .sof_out    (sof_out),
        .eof_out    (eof_out),
        .frame_err  (frame_err),
        .frames_cnt (frames_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] dat;
        logic        sof;
        logic        eof;
        logic        err;
        logic        fin;
    } beat_t;

    beat_t       q[$];
    int          n      = 0;
    logic        rst_q  = 1'b0;
    int          m_n    = 0;
    logic        m_drop = 1'b0;
    logic [15:0] m_hold = '0;
    logic [15:0] m_frames = '0;
    int          blk    = 0;

    task automatic push(input int c, input logic [31:0] d, input logic s, input logic e,
                        input logic er, input logic f);
        beat_t b;
        b.cyc = c; b.dat = d; b.sof = s; b.eof = e; b.err = er; b.fin = f;
        q.push_back(b);
    endtask

    // Pad beats start at cycle t; upstream is held off until the last one is on the wire.
    task automatic add_pad(input int t);
        for (int p = 0; p < PAD; p++) push(t + p, 32'h0, 1'b0, 1'b0, 1'b0, p == PAD - 1);
        blk = t + PAD - 2;
    endtask

    // Reference: a handshake in cycle c contributes beats from cycle c+1 onward.
    task automatic model_hs(input int c, input logic [15:0] d, input logic l);
        int   k;
        int   t;
        logic er;
        if (m_drop) begin
            if (l) begin
                add_pad(c + 2);
                m_drop = 1'b0;
            end
            return;
        end
        k  = m_n;
        er = l ? (k != FL - 1) : (k == FL - 1);
        if (k % 2 == 1) begin
            push(c + 1, {m_hold, d}, k == 1, k == FL - 1, er, 1'b0);
        end else begin
            m_hold = d;
            if (l) push(c + 1, {d, 16'h0000}, k == 0, k == FL - 2, er, 1'b0);
        end
        if (l) begin
            t = c + 2;
            for (int b = k / 2 + 1; b < HALF; b++) begin
                push(t, 32'h0, 1'b0, b == HALF - 1, 1'b0, 1'b0);
                t++;
            end
            add_pad(t);
            m_n = 0;
        end else if (k == FL - 1) begin
            m_drop = 1'b1;
            m_n    = 0;
        end else begin
            m_n = k + 1;
        end
    endtask

    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            n++;
            if (rst) begin
                if (rst_q)
                    check("rst_outs", 64'({s_ready, vld_out, sof_out, eof_out, frame_err, frames_cnt, data_out}), 64'(0));
                q.delete();
                m_n = 0; m_drop = 1'b0; m_frames = '0; blk = n;
            end else begin
                check("s_ready", 64'(s_ready), 64'(n > blk));
                if (q.size() > 0 && q[0].cyc == n) begin
                    b = q.pop_front();
                    check("beat", 64'({vld_out, sof_out, eof_out, frame_err, data_out}),
                          64'({1'b1, b.sof, b.eof, b.err, b.dat}));
                    if (b.fin) m_frames++;
                end else begin
                    check("idle", 64'({vld_out, frame_err}), 64'(0));
                end
                check("frames", 64'(frames_cnt), 64'(m_frames));
                if (s_valid && s_ready) model_hs(n, s_data, s_last);
            end
            rst_q = rst;
        end
    end

    task automatic idle(input int cycles);
        s_valid = 1'b0;
        repeat (cycles) begin
            s_data = 16'($urandom);
            s_last = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input logic [15:0] d, input logic l, input int gap);
        int   tries = 0;
        logic ok;
        s_valid = 1'b1; s_data = d; s_last = l;
        do begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk); #1;
            tries++;
        end while (!ok && tries < 100);
        if (!ok) check("hs_timeout", 64'(ok), 64'(1));
        idle(gap);
    endtask

    task automatic ramp_frame(input int len, input int gap);
        for (int i = 0; i < len; i++) send(16'(16'h0101 * (i + 1)), i == len - 1, gap);
    endtask

    task automatic expect_frames(input string tag, input logic [15:0] exp);
        idle(8);
        @(negedge clk);
        check(tag, 64'(frames_cnt), 64'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        int len;
        int r;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b0;

        ramp_frame(FL, 0);
        expect_frames("s1_frames", 16'd1);
        ramp_frame(FL, 1);
        expect_frames("s2_frames", 16'd2);
        ramp_frame(3, 0);
        expect_frames("s3_frames", 16'd3);
        ramp_frame(11, 0);
        ramp_frame(FL, 0);
        expect_frames("s4_frames", 16'd5);

        ramp_frame(5, 0);
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        ramp_frame(FL, 0);
        expect_frames("s5_frames", 16'd1);

        for (int f = 0; f < 400; f++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      len = FL;
            else if (r < 8) len = $urandom_range(1, FL - 1);
            else            len = $urandom_range(FL + 1, FL + 5);
            for (int i = 0; i < len; i++)
                send(16'($urandom), i == len - 1, ($urandom_range(0, 3) == 3) ? $urandom_range(1, 3) : 0);
        end

        idle(20);
        @(negedge clk);
        check("drain", 64'(q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
